// File: rtl/spcpu_mem_bridge.sv
// Bridge from the spcpu data port to a 16-bit byte-enabled memory with fixed wait states.
// Optional macro SPCPU_MEM_BRIDGE_MISALIGN_SPLIT_EN turns misaligned 16-bit accesses into two byte accesses.
module spcpu_mem_bridge #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_we,
    input  logic                  req_sz,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-2:0] mem_addr,
    output logic [1:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

`ifdef SPCPU_MEM_BRIDGE_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam logic [3:0]            WS       = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-2:0] WORD_ONE = (ADDR_WIDTH-1)'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCESS  = 3'd1,
        WAIT    = 3'd2,
        RESP    = 3'd3,
        ACCESS2 = 3'd4,
        WAIT2   = 3'd5
    } state_t;

    state_t                state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  we_reg;
    logic                  sz_reg;
    logic [15:0]           wdata_reg;
    logic                  err_reg;
    logic                  split_reg;
    logic [15:0]           rdata_reg;

    logic                  accept;
    logic                  misaligned;
    logic                  last_first;
    logic                  last_second;
    logic                  busy;
    logic                  phase2;
    logic [ADDR_WIDTH-2:0] word_first;
    logic [ADDR_WIDTH-2:0] word_second;
    logic [1:0]            be_cur;
    logic [15:0]           wdata_cur;

    assign accept      = req_valid && (state_reg == IDLE);
    assign misaligned  = req_sz && req_addr[0];
    // The access phase ends on the edge closing the last wait cycle, or ACCESS itself when there are none.
    assign last_first  = ((state_reg == ACCESS)  && (cnt_reg == 4'd0)) ||
                         ((state_reg == WAIT)    && (cnt_reg == 4'd1));
    assign last_second = ((state_reg == ACCESS2) && (cnt_reg == 4'd0)) ||
                         ((state_reg == WAIT2)   && (cnt_reg == 4'd1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    cnt_next   = WS;
                    state_next = (misaligned && !SPLIT_EN) ? RESP : ACCESS;
                end
            end
            ACCESS, WAIT: begin
                if (state_reg == WAIT) begin
                    cnt_next = cnt_reg - 4'd1;
                end
                if (last_first) begin
                    if (split_reg) begin
                        state_next = ACCESS2;
                        cnt_next   = WS;
                    end else begin
                        state_next = RESP;
                    end
                end else begin
                    state_next = WAIT;
                end
            end
            ACCESS2, WAIT2: begin
                if (state_reg == WAIT2) begin
                    cnt_next = cnt_reg - 4'd1;
                end
                state_next = last_second ? RESP : WAIT2;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch and read-data assembly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            sz_reg    <= 1'b0;
            wdata_reg <= 16'h0000;
            err_reg   <= 1'b0;
            split_reg <= 1'b0;
            rdata_reg <= 16'h0000;
        end else begin
            if (accept) begin
                addr_reg  <= req_addr;
                we_reg    <= req_we;
                sz_reg    <= req_sz;
                wdata_reg <= req_wdata;
                err_reg   <= misaligned && !SPLIT_EN;
                split_reg <= misaligned && SPLIT_EN;
                rdata_reg <= 16'h0000;
            end
            if (last_first && !we_reg) begin
                if (!sz_reg) begin
                    rdata_reg <= addr_reg[0] ? {8'h00, mem_rdata[7:0]} : {8'h00, mem_rdata[15:8]};
                end else if (split_reg) begin
                    rdata_reg[15:8] <= mem_rdata[7:0];
                end else begin
                    rdata_reg <= mem_rdata;
                end
            end
            if (last_second && !we_reg) begin
                rdata_reg[7:0] <= mem_rdata[15:8];
            end
        end
    end

    assign phase2      = (state_reg == ACCESS2) || (state_reg == WAIT2);
    assign busy        = (state_reg == ACCESS) || (state_reg == WAIT) || phase2;
    assign word_first  = addr_reg[ADDR_WIDTH-1:1];
    // A split access always starts at an odd byte, so its second byte is in the next word (wrapping).
    assign word_second = addr_reg[ADDR_WIDTH-1:1] + WORD_ONE;

    always_comb begin
        be_cur    = 2'b11;
        wdata_cur = wdata_reg;
        if (!sz_reg) begin
            be_cur    = addr_reg[0] ? 2'b01 : 2'b10;
            wdata_cur = addr_reg[0] ? {8'h00, wdata_reg[7:0]} : {wdata_reg[7:0], 8'h00};
        end else if (split_reg) begin
            be_cur    = phase2 ? 2'b10 : 2'b01;
            wdata_cur = phase2 ? {wdata_reg[7:0], 8'h00} : {8'h00, wdata_reg[15:8]};
        end
    end

    // Output logic; memory-side fields are held through the wait cycles and zero otherwise.
    always_comb begin
        req_ready  = (state_reg == IDLE);
        resp_valid = (state_reg == RESP);
        resp_err   = (state_reg == RESP) && err_reg;
        resp_rdata = (state_reg == RESP) ? rdata_reg : 16'h0000;
        mem_en     = (state_reg == ACCESS) || (state_reg == ACCESS2);
        mem_we     = busy && we_reg;
        mem_addr   = busy ? (phase2 ? word_second : word_first) : '0;
        mem_be     = busy ? be_cur : 2'b00;
        mem_wdata  = busy ? wdata_cur : 16'h0000;
    end

endmodule
